// File: rtl/wash_sequencer.sv
// Table-driven wash program sequencer: steps through a writable step table, one entry per step.
// Define WASH_SEQ_PAUSE_EN to enable the pause input; otherwise pause is ignored.
module wash_sequencer #(
   parameter int ADDR_WIDTH = 4,
   parameter int TIME_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   start_addr,
   input  logic                    abort,
   input  logic                    pause,
   input  logic                    wr_en,
   input  logic [ADDR_WIDTH-1:0]   wr_addr,
   input  logic [TIME_WIDTH+6:0]   wr_data,
   output logic                    ctrl_fill,
   output logic                    ctrl_release,
   output logic                    ctrl_forward,
   output logic                    ctrl_reverse,
   output logic                    sig_clean,
   output logic                    sig_rinse,
   output logic                    sig_dry,
   output logic                    sig_done,
   output logic                    busy,
   output logic [ADDR_WIDTH-1:0]   step_addr
);
   // state | meaning
   // IDLE  | no program; table writable
   // RUN   | executing step at r_addr, r_cnt cycles left
   // PAUSE | step frozen, motor and fill off
   // DONE  | program finished, sig_done high; table writable
   localparam int EW    = TIME_WIDTH + 7;
   localparam int DEPTH = 2 ** ADDR_WIDTH;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]            r_state;
   logic [EW-1:0]         r_table [DEPTH];
   logic [TIME_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [3:0]            r_ctrl;
   logic [2:0]            r_phase;
   logic                  r_done;

   logic                  w_pause_req;
   logic                  w_cur_last;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic [EW-1:0]         w_load;
   logic                  w_unused_load_last;

   function automatic logic [3:0] f_ctrl(input logic [3:0] c);
      logic [3:0] v;
      v = c;
      if (c[1] && c[0]) v[1:0] = 2'b00;
      return v;
   endfunction

   function automatic logic [2:0] f_phase(input logic [1:0] p);
      logic [2:0] v;
      v = 3'b000;
      case (p)
         2'b00:   v = 3'b100;
         2'b01:   v = 3'b010;
         2'b10:   v = 3'b001;
         default: v = 3'b000;
      endcase
      return v;
   endfunction

   function automatic logic [TIME_WIDTH-1:0] f_dur(input logic [TIME_WIDTH-1:0] d);
      return (d == '0) ? {{(TIME_WIDTH-1){1'b0}}, 1'b1} : d;
   endfunction

`ifdef WASH_SEQ_PAUSE_EN
   assign w_pause_req = pause;
`else
   logic w_unused_pause;
   assign w_unused_pause = pause;
   assign w_pause_req    = 1'b0;
`endif

   assign w_next_addr = r_addr + 1'b1;
   assign w_cur_last  = r_table[r_addr][6];

   // Entry to load this edge: the start entry, the following step, or the current step on resume.
   always_comb begin
      w_load = r_table[w_next_addr];
      if (r_state == ST_IDLE || r_state == ST_DONE) w_load = r_table[start_addr];
      else if (r_state == ST_PAUSE)                 w_load = r_table[r_addr];
   end
   assign w_unused_load_last = w_load[6];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_ctrl  <= '0;
         r_phase <= '0;
         r_done  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
      end else if (abort) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_ctrl  <= '0;
         r_phase <= '0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (wr_en) begin
                  r_table[wr_addr] <= wr_data;
               end else if (start) begin
                  r_state <= ST_RUN;
                  r_addr  <= start_addr;
                  r_cnt   <= f_dur(w_load[EW-1:7]);
                  r_ctrl  <= f_ctrl(w_load[3:0]);
                  r_phase <= f_phase(w_load[5:4]);
                  r_done  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (r_cnt <= {{(TIME_WIDTH-1){1'b0}}, 1'b1}) begin
                  if (w_cur_last) begin
                     r_state <= ST_DONE;
                     r_ctrl  <= '0;
                     r_phase <= '0;
                     r_done  <= 1'b1;
                  end else begin
                     r_addr  <= w_next_addr;
                     r_cnt   <= f_dur(w_load[EW-1:7]);
                     r_ctrl  <= f_ctrl(w_load[3:0]);
                     r_phase <= f_phase(w_load[5:4]);
                  end
               end else begin
                  // The edge that takes the pause request still consumes one count.
                  r_cnt <= r_cnt - 1'b1;
                  if (w_pause_req) begin
                     r_state <= ST_PAUSE;
                     r_ctrl  <= {1'b0, r_ctrl[2], 2'b00};
                  end
               end
            end
            ST_PAUSE: begin
               if (!w_pause_req) begin
                  r_state <= ST_RUN;
                  r_ctrl  <= f_ctrl(w_load[3:0]);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ctrl_fill    = r_ctrl[3];
   assign ctrl_release = r_ctrl[2];
   assign ctrl_forward = r_ctrl[1];
   assign ctrl_reverse = r_ctrl[0];
   assign sig_clean    = r_phase[2];
   assign sig_rinse    = r_phase[1];
   assign sig_dry      = r_phase[0];
   assign sig_done     = r_done;
   assign busy         = (r_state == ST_RUN) || (r_state == ST_PAUSE);
   assign step_addr    = r_addr;

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer: per-cycle expected output vectors queued, then compared.
module tb_wash_sequencer;
   logic        clk = 1'b0;
   logic        rst_n, start, abort, pause, wr_en;
   logic [1:0]  start_addr, wr_addr;
   logic [14:0] wr_data;
   logic        ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse;
   logic        sig_clean, sig_rinse, sig_dry, sig_done, busy;
   logic [1:0]  step_addr;

   int n_tests = 0;
   int n_fail  = 0;
   logic [10:0] sb[$];
   logic [10:0] exp_v;

   wash_sequencer #(.ADDR_WIDTH(2), .TIME_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
      .abort(abort), .pause(pause), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .ctrl_fill(ctrl_fill), .ctrl_release(ctrl_release),
      .ctrl_forward(ctrl_forward), .ctrl_reverse(ctrl_reverse),
      .sig_clean(sig_clean), .sig_rinse(sig_rinse), .sig_dry(sig_dry), .sig_done(sig_done),
      .busy(busy), .step_addr(step_addr)
   );

   always #5 clk = ~clk;

   wire [10:0] obs = {busy, sig_done, ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse,
                      sig_clean, sig_rinse, sig_dry, step_addr};

   function automatic logic [14:0] mk(input logic [7:0] dur, input logic last,
                                      input logic [1:0] ph, input logic [3:0] ctrl);
      return {dur, last, ph, ctrl};
   endfunction

   function automatic logic [10:0] ev(input logic b, input logic d, input logic [3:0] c,
                                      input logic [2:0] ph, input logic [1:0] a);
      return {b, d, c, ph, a};
   endfunction

   task automatic write_entry(input logic [1:0] a, input logic [14:0] d);
      @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk); wr_en = 1'b0;
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #9;
      n_tests++;
      if (obs !== 11'd0) begin
         n_fail++; $display("FAIL reset_async: got %b want %b", obs, 11'd0);
      end
      @(negedge clk); rst_n = 1'b1;
      sb.push_back(11'd0);
      @(negedge clk);
      exp_v = sb.pop_front(); n_tests++;
      if (obs !== exp_v) begin
         n_fail++; $display("FAIL reset_idle: got %b want %b", obs, exp_v);
      end
   endtask

   task automatic test_single_step();
      write_entry(2'd0, mk(8'd3, 1'b1, 2'b00, 4'b1000));
      repeat (3) sb.push_back(ev(1, 0, 4'b1000, 3'b100, 2'd0));
      repeat (2) sb.push_back(ev(0, 1, 4'b0000, 3'b000, 2'd0));
      @(negedge clk); start = 1'b1; start_addr = 2'd0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk); start = 1'b0;
         exp_v = sb.pop_front(); n_tests++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL single_step cycle %0d: got %b want %b", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_wrap();
      write_entry(2'd3, mk(8'd2, 1'b0, 2'b01, 4'b0100));
      write_entry(2'd0, mk(8'd0, 1'b1, 2'b10, 4'b0010));
      repeat (2) sb.push_back(ev(1, 0, 4'b0100, 3'b010, 2'd3));
      sb.push_back(ev(1, 0, 4'b0010, 3'b001, 2'd0));
      sb.push_back(ev(0, 1, 4'b0000, 3'b000, 2'd0));
      @(negedge clk); start = 1'b1; start_addr = 2'd3;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk); start = 1'b0;
         exp_v = sb.pop_front(); n_tests++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL wrap cycle %0d: got %b want %b", c, obs, exp_v);
         end
         if (c == 1) begin start = 1'b1; start_addr = 2'd1; end
      end
      start = 1'b0;
   endtask

   task automatic test_interlock();
      write_entry(2'd1, mk(8'd1, 1'b0, 2'b11, 4'b0011));
      write_entry(2'd2, mk(8'd1, 1'b1, 2'b00, 4'b1111));
      sb.push_back(ev(1, 0, 4'b0000, 3'b000, 2'd1));
      sb.push_back(ev(1, 0, 4'b1100, 3'b100, 2'd2));
      sb.push_back(ev(0, 1, 4'b0000, 3'b000, 2'd2));
      @(negedge clk); start = 1'b1; start_addr = 2'd1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk); start = 1'b0;
         exp_v = sb.pop_front(); n_tests++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL interlock cycle %0d: got %b want %b", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_abort();
      write_entry(2'd2, mk(8'd10, 1'b1, 2'b00, 4'b0110));
      repeat (4) sb.push_back(ev(1, 0, 4'b0110, 3'b100, 2'd2));
      sb.push_back(11'd0);
      repeat (3) sb.push_back(ev(1, 0, 4'b0110, 3'b100, 2'd2));
      sb.push_back(11'd0);
      @(negedge clk); start = 1'b1; start_addr = 2'd2;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk); start = 1'b0; wr_en = 1'b0; abort = 1'b0;
         exp_v = sb.pop_front(); n_tests++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL abort cycle %0d: got %b want %b", c, obs, exp_v);
         end
         if (c == 2) begin wr_en = 1'b1; wr_addr = 2'd2; wr_data = mk(8'd1, 1'b1, 2'b11, 4'b0000); end
         if (c == 4 || c == 8) abort = 1'b1;
         if (c == 5) begin start = 1'b1; start_addr = 2'd2; end
      end
      abort = 1'b0;
   endtask

   task automatic test_pause();
      write_entry(2'd1, mk(8'd5, 1'b1, 2'b00, 4'b0110));
`ifdef WASH_SEQ_PAUSE_EN
      repeat (3) sb.push_back(ev(1, 0, 4'b0110, 3'b100, 2'd1));
      repeat (3) sb.push_back(ev(1, 0, 4'b0100, 3'b100, 2'd1));
      repeat (2) sb.push_back(ev(1, 0, 4'b0110, 3'b100, 2'd1));
      sb.push_back(ev(0, 1, 4'b0000, 3'b000, 2'd1));
`else
      repeat (5) sb.push_back(ev(1, 0, 4'b0110, 3'b100, 2'd1));
      repeat (4) sb.push_back(ev(0, 1, 4'b0000, 3'b000, 2'd1));
`endif
      @(negedge clk); start = 1'b1; start_addr = 2'd1;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk); start = 1'b0;
         exp_v = sb.pop_front(); n_tests++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL pause cycle %0d: got %b want %b", c, obs, exp_v);
         end
         if (c == 3) pause = 1'b1;
         if (c == 6) pause = 1'b0;
      end
   endtask

   task automatic test_start_with_write();
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      repeat (2) sb.push_back(11'd0);
      repeat (2) sb.push_back(ev(1, 0, 4'b1000, 3'b010, 2'd3));
      sb.push_back(ev(0, 1, 4'b0000, 3'b000, 2'd3));
      start = 1'b1; start_addr = 2'd3;
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = mk(8'd2, 1'b1, 2'b01, 4'b1000);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk); start = 1'b0; wr_en = 1'b0;
         exp_v = sb.pop_front(); n_tests++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL start_with_write cycle %0d: got %b want %b", c, obs, exp_v);
         end
         if (c == 2) begin start = 1'b1; start_addr = 2'd3; end
      end
   endtask

   task automatic test_reset_midrun();
      sb.push_back(ev(1, 0, 4'b1000, 3'b010, 2'd3));
      sb.push_back(11'd0);
      sb.push_back(ev(1, 0, 4'b0000, 3'b100, 2'd3));
      sb.push_back(ev(1, 0, 4'b0000, 3'b100, 2'd0));
      @(negedge clk); start = 1'b1; start_addr = 2'd3;
      @(negedge clk); start = 1'b0;
      exp_v = sb.pop_front(); n_tests++;
      if (obs !== exp_v) begin
         n_fail++; $display("FAIL midrun_before_reset: got %b want %b", obs, exp_v);
      end
      #2 rst_n = 1'b0;
      #1;
      exp_v = sb.pop_front(); n_tests++;
      if (obs !== exp_v) begin
         n_fail++; $display("FAIL midrun_async_reset: got %b want %b", obs, exp_v);
      end
      @(negedge clk); rst_n = 1'b1;
      start = 1'b1; start_addr = 2'd3;
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk); start = 1'b0;
         exp_v = sb.pop_front(); n_tests++;
         if (obs !== exp_v) begin
            n_fail++; $display("FAIL table_cleared cycle %0d: got %b want %b", c, obs, exp_v);
         end
      end
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; wr_en = 1'b0;
      start_addr = '0; wr_addr = '0; wr_data = '0;
      test_reset();
      test_single_step();
      test_wrap();
      test_interlock();
      test_abort();
      test_pause();
      test_start_with_write();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wash_sequencer.md
WASH_SEQUENCER -- requirements
Module: wash_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, step-table address width; the table holds 2^ADDR_WIDTH entries.
REQ-002 Parameter TIME_WIDTH, default 8, step-duration width in clock cycles.
REQ-003 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port start  input  1  begins a program at start_addr.
REQ-006 Port start_addr  input  ADDR_WIDTH  first table entry of the program.
REQ-007 Port abort  input  1  cancels any activity.
REQ-008 Port pause  input  1  level-sensitive hold request (see Configuration).
REQ-009 Port wr_en, wr_addr, wr_data  input  1 / ADDR_WIDTH / TIME_WIDTH+7  step-table write port.
REQ-010 Port ctrl_fill, ctrl_release, ctrl_forward, ctrl_reverse  output  1 each  actuator controls, registered.
REQ-011 Port sig_clean, sig_rinse, sig_dry, sig_done  output  1 each  phase indicators, registered.
REQ-012 Port busy  output  1  high in RUN or PAUSE.
REQ-013 Port step_addr  output  ADDR_WIDTH  address of the current step.

Function
REQ-014 The entry format SHALL be: [TIME_WIDTH+6:7] duration; [6] last; [5:4] phase (00 clean, 01 rinse, 10 dry, 11 none); [3:0] fill, release, forward, reverse.
REQ-015 The FSM SHALL have four states, IDLE, RUN, PAUSE and DONE, with the following transitions:
 - IDLE or DONE to RUN on start;
 - RUN to DONE after the last step expires;
 - RUN to PAUSE and back per REQ-027;
 - any state to IDLE on abort.
REQ-016 start sampled in IDLE or DONE at edge t SHALL latch start_addr; entry[start_addr] drives the outputs from cycle t+1.
REQ-017 Each step SHALL last exactly max(duration,1) cycles, counted by a down-counter loaded on step entry.
REQ-018 On step expiry with last=0, step_addr SHALL increment modulo 2^ADDR_WIDTH, and the next entry SHALL drive the outputs in the following cycle with no gap cycle.
REQ-019 On step expiry with last=1, the FSM SHALL enter DONE:
 - all ctrl_* and phase signals go to 0;
 - sig_done goes to 1 and holds until start or abort.
REQ-020 An entry with forward=1 and reverse=1 SHALL drive both ctrl_forward and ctrl_reverse to 0 (motor interlock); the other bits are unaffected.
REQ-021 sig_clean/sig_rinse/sig_dry SHALL be the one-hot decode of phase while in RUN or PAUSE; phase 11 drives all three to 0.
REQ-022 Writes SHALL take effect only in IDLE or DONE; writes while busy=1 are dropped with no effect.
REQ-023 If wr_en and start coincide in IDLE or DONE, the write SHALL be performed and the start ignored.
REQ-024 abort SHALL have priority over every other input. The next edge forces IDLE, all outputs to 0, and step_addr to 0.
REQ-025 start while busy=1 SHALL be ignored.

Reset
REQ-026 rst_n low SHALL immediately force the following, independent of clk:
 - IDLE state;
 - all outputs 0, step_addr 0, counter 0;
 - table contents 0.

Configuration
REQ-027 Macro WASH_SEQ_PAUSE_EN, when defined, SHALL enable pause handling:
 - pause=1 in RUN enters PAUSE at the next edge;
 - in PAUSE the counter is frozen, ctrl_fill/ctrl_forward/ctrl_reverse are forced to 0, and ctrl_release and the phase signals hold;
 - pause=0 returns to RUN with the remaining count intact.
 When the macro is undefined, the pause port SHALL be present but ignored, and PAUSE is unreachable.

Verification
REQ-028 The bench SHALL cover a single step: load entry0 {dur=3,last=1,phase=00,ctrl=1000}; start at t. Required: fill=1 and clean=1 during t+1..t+3; sig_done=1 from t+4.
REQ-029 The bench SHALL cover a sequence with wrap: ADDR_WIDTH=2; entries 3 {dur=2,last=0} and 0 {dur=0,last=1}; start_addr=3. Required: step_addr 3,3,0, then DONE.
REQ-030 The bench SHALL cover the interlock: an entry with ctrl=0011 yields forward=0 and reverse=0.
REQ-031 The bench SHALL cover abort mid-step: dur=10, abort at cycle 4. Required: IDLE next edge, all outputs 0. A write during RUN is dropped.
REQ-032 The bench SHALL cover pause (WASH_SEQ_PAUSE_EN defined): dur=5, pause for 3 cycles after cycle 2. Required: the step lasts 8 cycles, with forward=0 and release held during the pause.
REQ-033 The bench SHALL cover start coinciding with wr_en in IDLE: the write is performed and busy stays 0.
